// File: rtl/axis_frame_pkg.sv
// Shared types and defaults for the AXI-Stream frame transmitter.
// The per-beat struct depends on module parameters, so it is declared
// inside axis_frame_tx; this package carries the FSM type and defaults.
package axis_frame_pkg;

    // Framing FSM: IDLE means no frame open, ACTIVE means a frame is open.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } frame_state_t;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned KEEP_W_DEF = DATA_W_DEF / 8;

    // Byte-enable width for a given data width.
    function automatic int unsigned keep_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry valid/ready skid buffer with registered outputs.
// Entry 0 is the output register and entry 1 is the skid slot.
// in_ready is registered and drops only when both entries are held.
// level_next is the occupancy after the coming edge. The sender side uses it
// to register its own status flags in step with the buffer.
module axis_skid_buf
    import axis_frame_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   level_next
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         in_ready_q, in_ready_d;
    logic         push_s, pop_s;

    // Next-state for both entries and the registered ready flag.
    always_comb begin
        push_s       = in_valid && in_ready_q;
        pop_s        = out_valid_q && out_ready;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q) begin
            // Empty: a pushed beat lands directly in the output register.
            if (push_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (!skid_valid_q) begin
            // One entry: push and pop together keep occupancy at one.
            if (pop_s && push_s) begin
                out_data_d = in_data;
            end else if (pop_s) begin
                out_valid_d = 1'b0;
            end else if (push_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                out_valid_d = 1'b1;
            end
        end else begin
            // Full: in_ready is low, so only a pop can happen.
            if (pop_s) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = !skid_valid_d;
        level_next = {1'b0, out_valid_d} + {1'b0, skid_valid_d};
    end

    // Buffer storage and ready flag; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {W{1'b0}};
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/axis_frame_tx.sv
// AXI-Stream frame transmitter. It groups upstream words into frames of
// cfg_len beats, or ends a frame early on s_last. Each beat is tagged with
// keep/last/id/dest and goes through a 2-entry skid buffer to the master port.
// Optional feature macro: AXIS_FRAME_TX_SOF_EN. When it is defined, TUSER marks
// the first beat of each frame. Otherwise TUSER is 0 and the SOF bit is not stored.
module axis_frame_tx
    import axis_frame_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DEST_W = 1,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_data,
    input  logic [DATA_W/8-1:0] s_keep,
    input  logic                s_last,
    input  logic [LEN_W-1:0]    cfg_len,
    input  logic [ID_W-1:0]     cfg_id,
    input  logic [DEST_W-1:0]   cfg_dest,
    output logic                TVALID,
    input  logic                TREADY,
    output logic [DATA_W-1:0]   TDATA,
    output logic [DATA_W/8-1:0] TKEEP,
    output logic [DATA_W/8-1:0] TSTRB,
    output logic [ID_W-1:0]     TID,
    output logic [DEST_W-1:0]   TDEST,
    output logic                TUSER,
    output logic                TLAST,
    output logic                busy,
    output logic [CNT_W-1:0]    frame_cnt
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
`ifdef AXIS_FRAME_TX_SOF_EN
        logic              sof;
`endif
        logic [ID_W-1:0]   id;
        logic [DEST_W-1:0] dest;
    } beat_t;

    frame_state_t      state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              busy_q, busy_d;

    logic              accept_s;
    logic              is_last_s;
    logic [LEN_W-1:0]  len_m1_s;
    logic [ID_W-1:0]   cur_id_s;
    logic [DEST_W-1:0] cur_dest_s;
    logic              skid_ready_s;
    logic              out_hs_s;
    logic [1:0]        level_next_s;
    beat_t             push_beat_s;
    beat_t             out_beat_s;

    // Framing FSM: tags the presented word and advances on acceptance.
    always_comb begin
        accept_s   = s_valid && skid_ready_s;
        len_m1_s   = len_q - LEN_ONE;
        state_d    = state_q;
        len_d      = len_q;
        id_d       = id_q;
        dest_d     = dest_q;
        beat_cnt_d = beat_cnt_q;
        is_last_s  = 1'b0;
        cur_id_s   = id_q;
        cur_dest_s = dest_q;
        case (state_q)
            IDLE: begin
                // The first word of a frame uses live cfg values and latches them.
                cur_id_s   = cfg_id;
                cur_dest_s = cfg_dest;
                is_last_s  = s_last || (cfg_len == LEN_ONE);
                if (accept_s) begin
                    len_d      = cfg_len;
                    id_d       = cfg_id;
                    dest_d     = cfg_dest;
                    beat_cnt_d = LEN_ONE;
                    state_d    = is_last_s ? IDLE : ACTIVE;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                // len_q==0 gives len_m1 all-ones, so the frame has 2^LEN_W beats.
                is_last_s = s_last || (beat_cnt_q == len_m1_s);
                if (accept_s) begin
                    beat_cnt_d = beat_cnt_q + LEN_ONE;
                    state_d    = is_last_s ? IDLE : ACTIVE;
                end else begin
                    state_d = ACTIVE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Beat assembly: s_keep counts only on the closing beat.
    always_comb begin
        push_beat_s.data = s_data;
        push_beat_s.keep = is_last_s ? s_keep : {KEEP_W{1'b1}};
        push_beat_s.last = is_last_s;
`ifdef AXIS_FRAME_TX_SOF_EN
        push_beat_s.sof  = (state_q == IDLE);
`endif
        push_beat_s.id   = cur_id_s;
        push_beat_s.dest = cur_dest_s;
    end

    axis_skid_buf #(
        .W($bits(beat_t))
    ) u_skid (
        .clk        (ACLK),
        .rst_n      (ARESETn),
        .in_valid   (s_valid),
        .in_ready   (skid_ready_s),
        .in_data    (push_beat_s),
        .out_valid  (TVALID),
        .out_ready  (TREADY),
        .out_data   (out_beat_s),
        .level_next (level_next_s)
    );

    // Completed-frame counter and busy flag, both registered from next-state.
    always_comb begin
        out_hs_s = TVALID && TREADY;
        if (out_hs_s && out_beat_s.last) begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        busy_d = (state_d == ACTIVE) || (level_next_s != 2'd0);
    end

    // State registers; reset discards any partial frame.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            len_q       <= {LEN_W{1'b0}};
            id_q        <= {ID_W{1'b0}};
            dest_q      <= {DEST_W{1'b0}};
            beat_cnt_q  <= {LEN_W{1'b0}};
            frame_cnt_q <= {CNT_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            id_q        <= id_d;
            dest_q      <= dest_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign s_ready   = skid_ready_s;
    assign TDATA     = out_beat_s.data;
    assign TKEEP     = out_beat_s.keep;
    assign TSTRB     = out_beat_s.keep;
    assign TID       = out_beat_s.id;
    assign TDEST     = out_beat_s.dest;
    assign TLAST     = out_beat_s.last;
`ifdef AXIS_FRAME_TX_SOF_EN
    assign TUSER     = out_beat_s.sof;
`else
    assign TUSER     = 1'b0;
`endif
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx. The main instance uses default parameters.
// A second small instance (LEN_W=2, CNT_W=2, DATA_W=8) covers the frame-length
// and counter wrap. Expected beats come from a small framing model in the bench.
module tb_axis_frame_tx;

    logic        ACLK;
    logic        ARESETn;
    logic        s_valid, s_ready, s_last;
    logic [15:0] s_data;
    logic [1:0]  s_keep;
    logic [7:0]  cfg_len, cfg_id;
    logic [0:0]  cfg_dest;
    logic        TVALID, TREADY, TUSER, TLAST, busy;
    logic [15:0] TDATA;
    logic [1:0]  TKEEP, TSTRB;
    logic [7:0]  TID;
    logic [0:0]  TDEST;
    logic [15:0] frame_cnt;

    logic        sm_s_valid, sm_s_ready, sm_s_last;
    logic [7:0]  sm_s_data;
    logic [0:0]  sm_s_keep;
    logic [1:0]  sm_cfg_len;
    logic [7:0]  sm_cfg_id;
    logic [0:0]  sm_cfg_dest;
    logic        sm_TVALID, sm_TREADY, sm_TUSER, sm_TLAST, sm_busy;
    logic [7:0]  sm_TDATA;
    logic [0:0]  sm_TKEEP, sm_TSTRB;
    logic [7:0]  sm_TID;
    logic [0:0]  sm_TDEST;
    logic [1:0]  sm_frame_cnt;

    int checks = 0;
    int errors = 0;

    // Per-word stimulus tables for the main instance.
    logic [15:0] w_data [256];
    logic        w_last [256];
    logic [1:0]  w_keep [256];
    logic [7:0]  w_len  [256];
    logic [7:0]  w_id   [256];
    logic [0:0]  w_dest [256];

    // Framing model state.
    logic        m_open;
    int          m_flen, m_pos, m_occ, m_fcnt;
    logic [7:0]  m_fid;
    logic [0:0]  m_fdest;
    logic [30:0] exp_q [$];

    axis_frame_tx u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_keep(s_keep),
        .s_last(s_last), .cfg_len(cfg_len), .cfg_id(cfg_id), .cfg_dest(cfg_dest),
        .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
        .TSTRB(TSTRB), .TID(TID), .TDEST(TDEST), .TUSER(TUSER), .TLAST(TLAST),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    axis_frame_tx #(.DATA_W(8), .ID_W(8), .DEST_W(1), .LEN_W(2), .CNT_W(2)) u_dut_small (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .s_valid(sm_s_valid), .s_ready(sm_s_ready), .s_data(sm_s_data),
        .s_keep(sm_s_keep), .s_last(sm_s_last), .cfg_len(sm_cfg_len),
        .cfg_id(sm_cfg_id), .cfg_dest(sm_cfg_dest),
        .TVALID(sm_TVALID), .TREADY(sm_TREADY), .TDATA(sm_TDATA), .TKEEP(sm_TKEEP),
        .TSTRB(sm_TSTRB), .TID(sm_TID), .TDEST(sm_TDEST), .TUSER(sm_TUSER),
        .TLAST(sm_TLAST), .busy(sm_busy), .frame_cnt(sm_frame_cnt)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [30:0] pay();
        return {TDATA, TKEEP, TSTRB, TID, TDEST, TUSER, TLAST};
    endfunction

    task automatic set_word(input int i, input logic [15:0] d, input logic l,
                            input logic [1:0] k, input logic [7:0] len,
                            input logic [7:0] id, input logic [0:0] dst);
        w_data[i] = d; w_last[i] = l; w_keep[i] = k;
        w_len[i] = len; w_id[i] = id; w_dest[i] = dst;
    endtask

    task automatic model_reset();
        m_open = 1'b0; m_flen = 0; m_pos = 0; m_occ = 0; m_fcnt = 0;
        m_fid = 8'h00; m_fdest = 1'b0;
        exp_q.delete();
    endtask

    // Per-cycle checks against the model, taken #1 after the edge.
    task automatic check_status();
        check("tvalid", TVALID, m_occ != 0);
        check("s_ready", s_ready, m_occ != 2);
        check("busy", busy, m_open || (m_occ != 0));
        check("frame_cnt", frame_cnt, 64'(16'(m_fcnt)));
    endtask

    // Streams words 0..n-1 from the tables with TREADY high rdy_pct% of cycles.
    task automatic run_stream(input int n, input int rdy_pct);
        int sent = 0;
        int cyc = 0;
        logic in_hs, out_hs, sof, last, prev_stall;
        logic [1:0]  keep;
        logic [30:0] prev_pay, exp_beat;
        prev_stall = 1'b0;
        prev_pay = 31'd0;
        while ((sent < n || exp_q.size() != 0) && cyc < 3000) begin
            s_valid = (sent < n);
            if (sent < n) begin
                s_data = w_data[sent]; s_keep = w_keep[sent]; s_last = w_last[sent];
                cfg_len = w_len[sent]; cfg_id = w_id[sent]; cfg_dest = w_dest[sent];
            end else begin
                s_last = 1'b0;
            end
            TREADY = ($urandom_range(99) < rdy_pct);
            #1;
            check_status();
            if (prev_stall) check("hold_payload", pay(), prev_pay);
            in_hs  = s_valid && s_ready;
            out_hs = TVALID && TREADY;
            if (out_hs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", pay(), exp_beat);
                    if (exp_beat[0]) m_fcnt++;
                end
            end
            if (in_hs) begin
                if (!m_open) begin
                    m_flen = (w_len[sent] == 8'd0) ? 256 : int'(w_len[sent]);
                    m_fid = w_id[sent]; m_fdest = w_dest[sent];
                    m_pos = 1; sof = 1'b1;
                end else begin
                    m_pos++; sof = 1'b0;
                end
                last = w_last[sent] || (m_pos == m_flen);
                keep = last ? w_keep[sent] : 2'b11;
`ifndef AXIS_FRAME_TX_SOF_EN
                sof = 1'b0;
`endif
                exp_q.push_back({w_data[sent], keep, keep, m_fid, m_fdest, sof, last});
                m_open = !last;
                sent++;
            end
            m_occ = m_occ + (in_hs ? 1 : 0) - (out_hs ? 1 : 0);
            prev_stall = TVALID && !TREADY;
            prev_pay = pay();
            @(posedge ACLK); #1;
            cyc++;
        end
        if (cyc >= 3000) check("stream_timeout", 1'b1, 1'b0);
        s_valid = 1'b0; s_last = 1'b0; TREADY = 1'b0;
        #1;
        check_status();
    endtask

    logic       sm_in_hs, sm_out_hs, sm_lastbeat;
    logic [1:0] sm_seq [5];
    int         sm_sent, sm_beats, sm_k;

    initial begin
        ARESETn = 1'b0;
        s_valid = 1'b0; s_data = 16'h0; s_keep = 2'b00; s_last = 1'b0;
        cfg_len = 8'd0; cfg_id = 8'h00; cfg_dest = 1'b0; TREADY = 1'b0;
        sm_s_valid = 1'b0; sm_s_data = 8'h0; sm_s_keep = 1'b1; sm_s_last = 1'b0;
        sm_cfg_len = 2'd0; sm_cfg_id = 8'h00; sm_cfg_dest = 1'b0; sm_TREADY = 1'b0;
        model_reset();

        // Reset state.
        #3;
        check("rst_tvalid", TVALID, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_payload", pay(), 31'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("rel_s_ready", s_ready, 1'b1);

        // Basic framing: len 4, data 1..8; s_keep on middle beats is ignored.
        for (int i = 0; i < 8; i++)
            set_word(i, 16'(i + 1), 1'b0, (((i % 4) == 3) ? 2'b11 : 2'b01), 8'd4, 8'h42, 1'b1);
        run_stream(8, 100);
        check("basic_frames", frame_cnt, 16'd2);

        // Early end on word 3 with keep 01; the next frame closes with s_last on word 6.
        for (int i = 0; i < 6; i++)
            set_word(i, 16'(16'h21 + i), 1'b0, 2'b11, 8'd8, 8'h07, 1'b0);
        w_last[2] = 1'b1; w_keep[2] = 2'b01;
        w_last[5] = 1'b1; w_keep[5] = 2'b10;
        run_stream(6, 100);
        check("early_frames", frame_cnt, 16'd4);

        // Backpressure: 100 words, len 5, TREADY at about 50% duty.
        for (int i = 0; i < 100; i++)
            set_word(i, 16'(i * 37 + 5), 1'b0, 2'b11, 8'd5, 8'h3C, 1'b1);
        run_stream(100, 50);
        check("bp_frames", frame_cnt, 16'd24);

        // Config latch: a 3-beat A5 frame, then cfg changes to 6/11 mid-frame.
        set_word(0, 16'hA000, 1'b0, 2'b11, 8'd3, 8'hA5, 1'b1);
        for (int i = 1; i < 9; i++)
            set_word(i, 16'(16'hA000 + i), 1'b0, 2'b11, 8'd6, 8'h11, 1'b0);
        run_stream(9, 70);
        check("cfg_frames", frame_cnt, 16'd26);

        // cfg_len 0 on the main instance means a 256-beat frame.
        for (int i = 0; i < 256; i++)
            set_word(i, 16'(i ^ 16'h5A00), 1'b0, 2'b11, 8'd0, 8'h99, 1'b0);
        run_stream(256, 100);
        check("len0_frames", frame_cnt, 16'd27);

        // Reset mid-frame: two beats held with TREADY low, then reset.
        s_valid = 1'b1; s_data = 16'h0101; s_keep = 2'b11; s_last = 1'b0;
        cfg_len = 8'd4; cfg_id = 8'h33; cfg_dest = 1'b0; TREADY = 1'b0;
        @(posedge ACLK); #1;
        s_data = 16'h0102;
        @(posedge ACLK); #1;
        s_valid = 1'b0;
        check("held_full_s_ready", s_ready, 1'b0);
        check("held_tdata", TDATA, 16'h0101);
        #2 ARESETn = 1'b0;
        #1;
        check("midrst_tvalid", TVALID, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        check("midrst_tlast", TLAST, 1'b0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(posedge ACLK); #1;
        check("midrst_rel_s_ready", s_ready, 1'b1);
        model_reset();
        for (int i = 0; i < 4; i++)
            set_word(i, 16'(16'hB001 + i), 1'b0, 2'b11, 8'd4, 8'h5E, 1'b1);
        run_stream(4, 100);
        check("post_rst_frames", frame_cnt, 16'd1);

        // Small instance: cfg_len 0 -> 4-beat frames; 2-bit frame count wraps.
        sm_seq[0] = 2'd1; sm_seq[1] = 2'd2; sm_seq[2] = 2'd3; sm_seq[3] = 2'd0; sm_seq[4] = 2'd1;
        sm_sent = 0; sm_beats = 0; sm_k = 0;
        sm_cfg_len = 2'd0; sm_TREADY = 1'b1;
        for (int c = 0; c < 80 && sm_k < 5; c++) begin
            sm_s_valid = (sm_sent < 20);
            sm_s_data = 8'(sm_sent + 1);
            #1;
            sm_in_hs = sm_s_valid && sm_s_ready;
            sm_out_hs = sm_TVALID && sm_TREADY;
            sm_lastbeat = sm_TLAST;
            if (sm_out_hs) begin
                check("sm_tlast", sm_TLAST, (sm_beats % 4) == 3);
                check("sm_tdata", sm_TDATA, 64'(sm_beats + 1));
                sm_beats++;
            end
            if (sm_in_hs) sm_sent++;
            @(posedge ACLK); #1;
            if (sm_out_hs && sm_lastbeat) begin
                check("sm_frame_cnt", sm_frame_cnt, sm_seq[sm_k]);
                sm_k++;
            end
        end
        check("sm_frames_seen", 64'(sm_k), 64'd5);
        sm_s_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
